modadd_ctrl: RTL

- Sequencer that computes modular addition/subtraction, (a ± b) mod M, using one shared 1027-bit multi-precision adder/subtractor. The adder (1-cycle registered carry-select core with start/done) is instantiated alongside this block.
- Issues two adder operations per request: the raw add/sub, then a correction by M. Selects the final value from the first result's borrow/overflow.
- Latency is constant, so run time never depends on operand values (side-channel requirement). Sits between the exponentiation/Montgomery top-level FSM and the adder.

---
 rtl/modadd_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/modadd_ctrl.sv
// Modular add/subtract sequencer: (a +/- b) mod M computed as two passes through
// a shared multi-precision adder (raw op, then correction by M), constant latency.
module modadd_ctrl #(
  parameter int W = 1027
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic         op_sub,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [W-1:0] in_m,
  output logic [W-1:0] result,
  output logic         busy,
  output logic         done,
  output logic         add_start,
  output logic         add_subtract,
  output logic [W-1:0] add_in_a,
  output logic [W-1:0] add_in_b,
  input  logic [W:0]   add_result,
  input  logic         add_done
);

  // state  | meaning
  // IDLE   | waiting for start; result held from the last request
  // ISSUE1 | add_start pulse for the raw a +/- b operation
  // WAIT1  | adder busy on raw op; operands held until add_done
  // ISSUE2 | add_start pulse for the correction r1 -/+ M
  // WAIT2  | adder busy on correction; final selection on add_done
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ISSUE1 = 3'd1;
  localparam logic [2:0] WAIT1  = 3'd2;
  localparam logic [2:0] ISSUE2 = 3'd3;
  localparam logic [2:0] WAIT2  = 3'd4;

  logic [2:0]   state_q;
  logic         op_q;
  logic [W-1:0] m_q;
  logic [W-1:0] r1_q;
  logic         f1_q;
  logic [W-1:0] r2;
  logic         f2;
  logic [W-1:0] final_val;

  assign r2 = add_result[W-1:0];
  assign f2 = add_result[W];

  // Add path: a negative r1-M means r1 was already reduced.
  // Sub path: a borrow on a-b means the +M correction is the answer.
  always_comb begin
    final_val = r2;
    if (op_q) begin
      final_val = f1_q ? r2 : r1_q;
    end else begin
      final_val = f2 ? r1_q : r2;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      op_q         <= 1'b0;
      m_q          <= '0;
      r1_q         <= '0;
      f1_q         <= 1'b0;
      result       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      add_start    <= 1'b0;
      add_subtract <= 1'b0;
      add_in_a     <= '0;
      add_in_b     <= '0;
    end else begin
      done      <= 1'b0;
      add_start <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q         <= op_sub;
            m_q          <= in_m;
            add_in_a     <= in_a;
            add_in_b     <= in_b;
            add_subtract <= op_sub;
            add_start    <= 1'b1;
            busy         <= 1'b1;
            state_q      <= ISSUE1;
          end
        end
        ISSUE1: state_q <= WAIT1;
        WAIT1: begin
          if (add_done) begin
            r1_q         <= add_result[W-1:0];
            f1_q         <= add_result[W];
            add_in_a     <= add_result[W-1:0];
            add_in_b     <= m_q;
            add_subtract <= ~op_q;
            add_start    <= 1'b1;
            state_q      <= ISSUE2;
          end
        end
        ISSUE2: state_q <= WAIT2;
        WAIT2: begin
          if (add_done) begin
            result  <= final_val;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
